// File: rtl/systolic_pq_arbiter.sv
// Round-robin insert arbiter in front of a systolic priority queue.
// It holds one accepted entry in OFFER until the queue takes it, and tracks queue occupancy.
module systolic_pq_arbiter #(
    parameter int KW    = 8,
    parameter int VW    = 4,
    parameter int NREQ  = 4,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ*(KW+VW)-1:0]        req_data,
    output logic [NREQ-1:0]                req_rdy,
    output logic                           pq_ivalid,
    output logic [KW+VW-1:0]               pq_idata,
    input  logic                           pq_irdy,
    input  logic                           pq_ovalid,
    input  logic                           pq_ordy,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id
);

    localparam int EW = KW + VW;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_R = (CW + 1)'(DEPTH);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   winner;
    logic            found;
    logic [EW-1:0]   win_data;
    logic [CW:0]     reserved;
    logic            accept;
    logic            ins_xfer;
    logic            ext_xfer;

    // Occupancy update that holds at both ends and cancels simultaneous insert/extract.
    function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c,
                                                input logic inc, input logic dec);
        if (inc && !dec && (c < DEPTH_C))
            return c + CW'(1);
        if (dec && !inc && (c != '0))
            return c - CW'(1);
        return c;
    endfunction

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
        if (int'(p) == NREQ - 1)
            return '0;
        return p + IW'(1);
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        logic [IW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IW'(k) == winner)
                win_data = req_data[k*EW +: EW];
        end
    end

    assign reserved = {1'b0, count} + (CW + 1)'(state == OFFER);
    assign ins_xfer = pq_ivalid & pq_irdy;
    assign ext_xfer = pq_ovalid & pq_ordy;

    always_comb begin
        state_nxt = state;
        req_rdy   = '0;
        pq_ivalid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (found && (reserved < DEPTH_R)) begin
                    accept          = 1'b1;
                    req_rdy[winner] = 1'b1;
                    state_nxt       = OFFER;
                end
            end
            OFFER: begin
                pq_ivalid = 1'b1;
                if (pq_irdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            count    <= '0;
            grant_id <= '0;
            pq_idata <= '0;
        end else begin
            state <= state_nxt;
            count <= sat_count(count, ins_xfer, ext_xfer);
            if (accept) begin
                grant_id <= winner;
                pq_idata <= win_data;
            end
            if (ins_xfer)
                rr_ptr <= wrap_inc(grant_id);
        end
    end

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: tb/tb_systolic_pq_arbiter.sv
// Directed self-checking bench for systolic_pq_arbiter at KW=8, VW=4, NREQ=4, DEPTH=16.
module tb_systolic_pq_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [47:0] req_data;
    logic [3:0]  req_rdy;
    logic        pq_ivalid;
    logic [11:0] pq_idata;
    logic        pq_irdy;
    logic        pq_ovalid;
    logic        pq_ordy;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_pq_arbiter #(.KW(8), .VW(4), .NREQ(4), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_rdy(req_rdy),
        .pq_ivalid(pq_ivalid), .pq_idata(pq_idata), .pq_irdy(pq_irdy),
        .pq_ovalid(pq_ovalid), .pq_ordy(pq_ordy),
        .count(count), .full(full), .empty(empty), .grant_id(grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] lane [4];
        lane[0] = 12'hA00; lane[1] = 12'hB11; lane[2] = 12'hC22; lane[3] = 12'hD33;

        rst = 1'b1; req_valid = '0; req_data = '0;
        pq_irdy = 1'b0; pq_ovalid = 1'b0; pq_ordy = 1'b0;
        tick(); tick();
        chk("rst_req_rdy", 32'(req_rdy), 0);
        chk("rst_ivalid", 32'(pq_ivalid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_idata", 32'(pq_idata), 0);
        rst = 1'b0;

        // single insert
        req_valid = 4'b0001; req_data = {36'h0, 12'h111}; pq_irdy = 1'b1;
        #1;
        chk("single_rdy", 32'(req_rdy), 32'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("single_rdy_off", 32'(req_rdy), 0);
        chk("single_ivalid", 32'(pq_ivalid), 1);
        chk("single_idata", 32'(pq_idata), 32'h111);
        chk("single_count0", 32'(count), 0);
        tick();
        chk("single_count1", 32'(count), 1);
        chk("single_empty", 32'(empty), 0);
        chk("single_ivalid_off", 32'(pq_ivalid), 0);

        // round robin from a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        req_data = {lane[3], lane[2], lane[1], lane[0]};
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("rr_rdy", 32'(req_rdy), 32'(1 << (g % 4)));
            tick();
            chk("rr_rdy_off", 32'(req_rdy), 0);
            chk("rr_ivalid", 32'(pq_ivalid), 1);
            chk("rr_grant", 32'(grant_id), 32'(g % 4));
            chk("rr_idata", 32'(pq_idata), 32'(lane[g % 4]));
            tick();
        end
        chk("rr_count", 32'(count), 5);

        // insert and extract in the same cycle at count 5
        #1;
        chk("both_rdy", 32'(req_rdy), 32'h2);
        tick();
        pq_ovalid = 1'b1; pq_ordy = 1'b1;
        #1;
        chk("both_ivalid", 32'(pq_ivalid), 1);
        tick();
        pq_ovalid = 1'b0; pq_ordy = 1'b0;

        // stall in OFFER for five cycles
        req_valid = 4'b0100; pq_irdy = 1'b0;
        #1;
        chk("both_count", 32'(count), 5);
        chk("stall_rdy", 32'(req_rdy), 32'h4);
        tick();
        req_valid = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("stall_idata", 32'(pq_idata), 32'hC22);
            chk("stall_ivalid", 32'(pq_ivalid), 1);
            chk("stall_no_rdy", 32'(req_rdy), 0);
            chk("stall_count", 32'(count), 5);
            tick();
        end
        req_valid = 4'b0000; pq_irdy = 1'b1;
        #1;
        chk("stall_idata_last", 32'(pq_idata), 32'hC22);
        chk("stall_ivalid_last", 32'(pq_ivalid), 1);
        tick();
        chk("stall_count_after", 32'(count), 6);

        // fill to capacity
        req_valid = 4'b0001;
        for (int f = 0; f < 10; f++) begin
            tick(); tick();
        end
        req_valid = 4'b1111;
        #1;
        chk("fill_count", 32'(count), 16);
        chk("fill_full", 32'(full), 1);
        chk("fill_empty", 32'(empty), 0);
        chk("fill_no_rdy", 32'(req_rdy), 0);
        tick();
        chk("fill_no_rdy2", 32'(req_rdy), 0);
        chk("fill_no_ivalid", 32'(pq_ivalid), 0);

        // one extract frees a slot; lane 1 now carries 12'h304
        req_data = {lane[3], lane[2], 12'h304, lane[0]};
        pq_ovalid = 1'b1; pq_ordy = 1'b1;
        #1;
        chk("ext_no_rdy", 32'(req_rdy), 0);
        tick();
        pq_ovalid = 1'b0; pq_ordy = 1'b0;
        #1;
        chk("ext_count", 32'(count), 15);
        chk("ext_full", 32'(full), 0);
        chk("ext_rdy", 32'(req_rdy), 32'h2);
        tick();
        chk("hold_idata", 32'(pq_idata), 32'h304);
        chk("hold_grant", 32'(grant_id), 1);
        chk("hold_ivalid", 32'(pq_ivalid), 1);

        // reset while offering, with the queue ready: reset wins
        rst = 1'b1;
        tick();
        rst = 1'b0; req_valid = 4'b0000;
        #1;
        chk("roff_ivalid", 32'(pq_ivalid), 0);
        chk("roff_count", 32'(count), 0);
        chk("roff_empty", 32'(empty), 1);
        chk("roff_grant", 32'(grant_id), 0);
        chk("roff_idata", 32'(pq_idata), 0);
        req_valid = 4'b1111;
        #1;
        chk("roff_ptr", 32'(req_rdy), 32'h1);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("roff_count_after", 32'(count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_pq_arbiter.md
SYSTOLIC_PQ_ARBITER -- requirements
Module: systolic_pq_arbiter

Interface
REQ-001 Parameter KW, default 8: key width in bits.
REQ-002 Parameter VW, default 4: value width in bits.
REQ-003 Parameter NREQ, default 4: number of insert requesters.
REQ-004 Parameter DEPTH, default 16: queue capacity in entries, matching the attached systolic_pq.
REQ-005 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port req_valid, input, NREQ: requester i offers an entry.
REQ-008 Port req_data, input, NREQ*(KW+VW): entry for requester i at bits [i*(KW+VW) +: KW+VW], key in the MSBs.
REQ-009 Port req_rdy, output, NREQ: one-hot accept strobe to requester i.
REQ-010 Port pq_ivalid, output, 1: insert valid to the queue.
REQ-011 Port pq_idata, output, KW+VW: insert entry to the queue.
REQ-012 Port pq_irdy, input, 1: queue insert ready.
REQ-013 Port pq_ovalid, input, 1: queue extract valid (monitored only).
REQ-014 Port pq_ordy, input, 1: consumer extract ready (monitored only).
REQ-015 Port count, output, $clog2(DEPTH+1): current queue occupancy.
REQ-016 Port full, output, 1: asserted when count == DEPTH.
REQ-017 Port empty, output, 1: asserted when count == 0.
REQ-018 Port grant_id, output, $clog2(NREQ): index of the requester whose entry is held in OFFER.

Function
REQ-019 The FSM SHALL have two states: IDLE and OFFER.
REQ-020 In IDLE, when no candidate request exists or reserved >= DEPTH, the block SHALL stay in IDLE with req_rdy = 0; reserved = count + (state==OFFER).
REQ-021 Otherwise it SHALL pick the first valid requester in round-robin order, starting at pointer rr_ptr and wrapping modulo NREQ.
REQ-022 In that same IDLE cycle the block SHALL pulse req_rdy[winner] for exactly one cycle, capture the winner's data into pq_idata, load grant_id, and go to OFFER.
REQ-023 In OFFER, pq_ivalid SHALL be 1; pq_idata and grant_id SHALL stay stable; req_rdy SHALL be all zeros.
REQ-024 In OFFER, on the cycle with pq_irdy = 1, the insert SHALL transfer; rr_ptr SHALL become (grant_id+1) mod NREQ; the FSM SHALL return to IDLE.
REQ-025 Maximum insert throughput SHALL be one entry per 2 cycles; accept-to-pq_ivalid latency SHALL be 1 cycle.
REQ-026 count SHALL increment on an insert transfer (pq_ivalid & pq_irdy).
REQ-027 count SHALL decrement on an extract transfer (pq_ovalid & pq_ordy).
REQ-028 When an insert and an extract transfer occur in the same cycle, count SHALL be unchanged.
REQ-029 count SHALL saturate at 0 and at DEPTH; an extract while count == 0 or an insert while count == DEPTH SHALL leave count unchanged.
REQ-030 full and empty SHALL be combinational decodes of count.
REQ-031 A requester that drops req_valid while not accepted SHALL simply lose its turn; no state SHALL change.

Reset
REQ-032 On rst = 1 at a clock edge: state = IDLE, rr_ptr = 0, count = 0, grant_id = 0, pq_idata = 0; hence pq_ivalid = 0, req_rdy = 0, empty = 1, full = 0.
REQ-033 Reset asserted while in OFFER SHALL discard the held entry without a transfer and without a count change.
REQ-034 Reset SHALL take priority over all other events in the same cycle.

Verification (KW=8, VW=4, NREQ=4, DEPTH=16)
REQ-035 After reset, req_valid=4'b0001, data 12'h111, pq_irdy=1 -> req_rdy=0001 for 1 cycle; next cycle pq_ivalid=1, pq_idata=12'h111; count 0->1; empty deasserts.
REQ-036 req_valid=4'b1111 held constant, pq_irdy=1 -> grants issued in order 0,1,2,3,0; one accept every 2 cycles.
REQ-037 OFFER with pq_irdy=0 for 5 cycles, then 1 -> pq_idata is stable for all 6 cycles; exactly one count increment; no req_rdy pulses during the stall.
REQ-038 Fill to 16 entries -> full=1; further requests get no req_rdy. A single extract (pq_ovalid=pq_ordy=1) -> count=15; the next request is granted.
REQ-039 Insert transfer and extract transfer in the same cycle at count=5 -> count stays 5.
REQ-040 rst asserted in OFFER holding 12'h304 -> next cycle pq_ivalid=0, count=0, rr_ptr=0; no insert observed.
